// File: rtl/ahb_sram_slave.sv
// AHB-Lite responder over a word-addressed SRAM; OKAY data phase after WAIT_STATES stall cycles, ERROR is a fixed two-cycle response.
// Holds HREADYOUT low only in WAIT and the first ERROR cycle; a held NONSEQ is taken once bus HREADY returns high.
module ahb_sram_slave #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 0,
    parameter int READ_ONLY   = 0
) (
    input  logic        HCLK,
    input  logic        HRST_N,
    input  logic        HSEL_i,
    input  logic [31:0] HADDR_i,
    input  logic [1:0]  HTRANS_i,
    input  logic        HWRITE_i,
    input  logic [2:0]  HSIZE_i,
    input  logic [31:0] HWDATA_i,
    input  logic        HREADY_i,
    output logic [31:0] HRDATA_o,
    output logic        HREADYOUT_o,
    output logic        HRESP_o
);
    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WS_LOAD   = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic [26:0] DEPTH_LIM = 27'(DEPTH_WORDS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_OK,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      wcnt_q, wcnt_d;
    logic [AW-1:0]   idx_q;
    logic [1:0]      off_q;
    logic [1:0]      size_q;
    logic            write_q;
    logic            err_q;

    logic [31:0]     mem [DEPTH_WORDS];

    logic            ready_int;
    logic            accept;
    logic            take;
    logic            idx_oob;
    logic            misalign;
    logic            err_d;
    logic            commit;
    logic [3:0]      strb;
    logic            unused_in;

    // HADDR[31:28] is decoded upstream; HTRANS[0] only separates NONSEQ/SEQ, which we treat alike.
    assign unused_in = ^{HTRANS_i[0], HADDR_i[31:28]};

    assign ready_int = (state_q != S_WAIT) && (state_q != S_ERR1);
    assign accept    = HSEL_i & HTRANS_i[1] & HREADY_i;
    assign take      = accept & ready_int;

    assign idx_oob   = {1'b0, HADDR_i[27:2]} >= DEPTH_LIM;
    assign misalign  = ((HSIZE_i == 3'b001) && HADDR_i[0]) ||
                       ((HSIZE_i == 3'b010) && (HADDR_i[1:0] != 2'b00));
    assign err_d     = (HSIZE_i > 3'b010) || misalign || idx_oob ||
                       ((READ_ONLY != 0) && HWRITE_i);

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        case (state_q)
            S_IDLE, S_OK, S_ERR2: begin
                if (take) begin
                    if (err_d) begin
                        state_d = S_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                        wcnt_d  = WS_LOAD;
                    end else begin
                        state_d = S_OK;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (wcnt_q == 4'd0) begin
                    state_d = S_OK;
                end else begin
                    wcnt_d = wcnt_q - 4'd1;
                end
            end
            S_ERR1:  state_d = S_ERR2;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRST_N) begin
        if (!HRST_N) begin
            state_q <= S_IDLE;
            wcnt_q  <= 4'd0;
            idx_q   <= '0;
            off_q   <= 2'b00;
            size_q  <= 2'b00;
            write_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            if (take) begin
                idx_q   <= HADDR_i[AW+1:2];
                off_q   <= HADDR_i[1:0];
                size_q  <= HSIZE_i[1:0];
                write_q <= HWRITE_i;
                err_q   <= err_d;
            end
        end
    end

    always_comb begin
        strb = 4'b0000;
        case (size_q)
            2'b00:   strb = 4'b0001 << off_q;
            2'b01:   strb = off_q[1] ? 4'b1100 : 4'b0011;
            default: strb = 4'b1111;
        endcase
    end

    // Errored transfers never reach OK, err_q is a second guard on the array.
    assign commit = (state_q == S_OK) && write_q && !err_q;

    always_ff @(posedge HCLK) begin
        if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) begin
                    mem[idx_q][8*b +: 8] <= HWDATA_i[8*b +: 8];
                end
            end
        end
    end

    // Combinational read so a read chained after a write sees the committed word.
    assign HRDATA_o    = ((state_q == S_OK) && !write_q) ? mem[idx_q] : 32'h0;
    assign HREADYOUT_o = ready_int;
    assign HRESP_o     = (state_q == S_ERR1) || (state_q == S_ERR2);

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench: three slaves (no wait, two wait states, read-only), each alone on its bus.
module tb_ahb_sram_slave;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        hsel      [3];
    logic [31:0] haddr     [3];
    logic [1:0]  htrans    [3];
    logic        hwrite    [3];
    logic [2:0]  hsize     [3];
    logic [31:0] hwdata    [3];
    logic [31:0] hrdata    [3];
    logic        hreadyout [3];
    logic        hresp     [3];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        ahb_sram_slave #(
            .DEPTH_WORDS(1024),
            .WAIT_STATES((g == 1) ? 2 : 0),
            .READ_ONLY((g == 2) ? 1 : 0)
        ) u_dut (
            .HCLK(clk),
            .HRST_N(rst_n),
            .HSEL_i(hsel[g]),
            .HADDR_i(haddr[g]),
            .HTRANS_i(htrans[g]),
            .HWRITE_i(hwrite[g]),
            .HSIZE_i(hsize[g]),
            .HWDATA_i(hwdata[g]),
            .HREADY_i(hreadyout[g]),
            .HRDATA_o(hrdata[g]),
            .HREADYOUT_o(hreadyout[g]),
            .HRESP_o(hresp[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic addr_phase(input int d, input logic wr, input logic [31:0] a, input logic [2:0] sz);
        hsel[d]   = 1'b1;
        htrans[d] = 2'b10;
        hwrite[d] = wr;
        haddr[d]  = a;
        hsize[d]  = sz;
    endtask

    task automatic idle(input int d);
        hsel[d]   = 1'b0;
        htrans[d] = 2'b00;
    endtask

    // Returns at the negedge of the cycle in which HREADYOUT is high.
    task automatic data_phase(input int d, input logic [31:0] wd, output int waits,
                              output logic [31:0] rd, output logic rf, output logic rl);
        hwdata[d] = wd;
        waits = 0;
        rd = '0;
        rf = 1'b0;
        rl = 1'b0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (i == 0) rf = hresp[d];
            if (hreadyout[d]) begin
                rd = hrdata[d];
                rl = hresp[d];
                return;
            end
            waits++;
            @(posedge clk);
            #1;
        end
        chk("data_phase_timeout", waits, 32'd0);
    endtask

    task automatic xfer(input int d, input logic wr, input logic [31:0] a, input logic [2:0] sz,
                        input logic [31:0] wd, output int waits, output logic [31:0] rd,
                        output logic rf, output logic rl);
        addr_phase(d, wr, a, sz);
        step();
        idle(d);
        data_phase(d, wd, waits, rd, rf, rl);
        step();
    endtask

    int          w;
    logic [31:0] rd;
    logic [31:0] pre;
    logic        rf, rl;

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            hsel[i] = 1'b0; haddr[i] = '0; htrans[i] = 2'b00;
            hwrite[i] = 1'b0; hsize[i] = 3'b010; hwdata[i] = '0;
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_hreadyout", 32'(hreadyout[i]), 32'd1);
            chk("rst_hresp",     32'(hresp[i]),     32'd0);
            chk("rst_hrdata",    hrdata[i],         32'h0);
        end
        step();

        // Zero wait states: write then read of 0x10 back to back
        addr_phase(0, 1'b1, 32'h10, 3'b010);
        step();
        addr_phase(0, 1'b0, 32'h10, 3'b010);
        data_phase(0, 32'hDEADBEEF, w, rd, rf, rl);
        chk("ws0_wr_waits", w, 32'd0);
        chk("ws0_wr_resp", 32'(rl), 32'd0);
        chk("ws0_wr_hrdata", rd, 32'h0);
        step();
        idle(0);
        data_phase(0, 32'h0, w, rd, rf, rl);
        chk("ws0_rd_waits", w, 32'd0);
        chk("ws0_rd_data", rd, 32'hDEADBEEF);
        chk("ws0_rd_resp", 32'(rl), 32'd0);
        step();
        @(negedge clk);
        chk("ws0_idle_ready", 32'(hreadyout[0]), 32'd1);
        step();

        // Two wait states, second NONSEQ held while HREADY low
        xfer(1, 1'b1, 32'h4, 3'b010, 32'hCAFE0004, w, rd, rf, rl);
        chk("ws2_wr_waits", w, 32'd2);
        addr_phase(1, 1'b0, 32'h4, 3'b010);
        step();
        addr_phase(1, 1'b0, 32'h4, 3'b010);
        data_phase(1, 32'h0, w, rd, rf, rl);
        chk("ws2_rd1_waits", w, 32'd2);
        chk("ws2_rd1_data", rd, 32'hCAFE0004);
        chk("ws2_rd1_resp", 32'(rl), 32'd0);
        step();
        idle(1);
        data_phase(1, 32'h0, w, rd, rf, rl);
        chk("ws2_rd2_waits", w, 32'd2);
        chk("ws2_rd2_data", rd, 32'hCAFE0004);
        step();
        @(negedge clk);
        chk("ws2_idle_ready", 32'(hreadyout[1]), 32'd1);
        step();

        // Byte and halfword writes
        xfer(0, 1'b1, 32'h0, 3'b010, 32'h11223344, w, rd, rf, rl);
        xfer(0, 1'b1, 32'h1, 3'b000, 32'h0000AA00, w, rd, rf, rl);
        xfer(0, 1'b0, 32'h0, 3'b010, 32'h0, w, rd, rf, rl);
        chk("byte_wr", rd, 32'h1122AA44);
        xfer(0, 1'b1, 32'h2, 3'b001, 32'hBBCC0000, w, rd, rf, rl);
        xfer(0, 1'b0, 32'h0, 3'b010, 32'h0, w, rd, rf, rl);
        chk("half_wr", rd, 32'hBBCCAA44);

        // ERROR responses: misaligned word, out-of-range index, misaligned half, bad size
        xfer(0, 1'b1, 32'h2, 3'b010, 32'hFFFFFFFF, w, rd, rf, rl);
        chk("err_mis_waits", w, 32'd1);
        chk("err_mis_resp1", 32'(rf), 32'd1);
        chk("err_mis_resp2", 32'(rl), 32'd1);
        xfer(0, 1'b1, 32'h1000, 3'b010, 32'hFFFFFFFF, w, rd, rf, rl);
        chk("err_oob_waits", w, 32'd1);
        chk("err_oob_resp1", 32'(rf), 32'd1);
        chk("err_oob_resp2", 32'(rl), 32'd1);
        xfer(0, 1'b1, 32'h3, 3'b001, 32'hFFFFFFFF, w, rd, rf, rl);
        chk("err_half_resp", 32'(rf), 32'd1);
        xfer(0, 1'b0, 32'h0, 3'b011, 32'h0, w, rd, rf, rl);
        chk("err_size_resp", 32'(rl), 32'd1);
        chk("err_size_data", rd, 32'h0);
        xfer(0, 1'b0, 32'h0, 3'b010, 32'h0, w, rd, rf, rl);
        chk("err_unchanged", rd, 32'hBBCCAA44);
        chk("err_after_resp", 32'(rl), 32'd0);

        // Read-only instance
        xfer(2, 1'b0, 32'h8, 3'b010, 32'h0, w, pre, rf, rl);
        xfer(2, 1'b1, 32'h8, 3'b010, ~pre, w, rd, rf, rl);
        chk("ro_wr_waits", w, 32'd1);
        chk("ro_wr_resp1", 32'(rf), 32'd1);
        chk("ro_wr_resp2", 32'(rl), 32'd1);
        xfer(2, 1'b0, 32'h8, 3'b010, 32'h0, w, rd, rf, rl);
        chk("ro_unchanged", rd, pre);
        chk("ro_rd_resp", 32'(rl), 32'd0);

        // Reset during a WAIT cycle
        addr_phase(1, 1'b0, 32'h4, 3'b010);
        step();
        idle(1);
        @(negedge clk);
        chk("rst_mid_wait", 32'(hreadyout[1]), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_async_ready", 32'(hreadyout[1]), 32'd1);
        chk("rst_async_resp",  32'(hresp[1]),     32'd0);
        chk("rst_async_data",  hrdata[1],         32'h0);
        step();
        step();
        rst_n = 1'b1;
        hsel[1] = 1'b1;
        htrans[1] = 2'b00;
        step();
        idle(1);
        @(negedge clk);
        chk("post_rst_idle_ready", 32'(hreadyout[1]), 32'd1);
        chk("post_rst_idle_resp",  32'(hresp[1]),     32'd0);
        step();
        xfer(1, 1'b0, 32'h4, 3'b010, 32'h0, w, rd, rf, rl);
        chk("post_rst_data", rd, 32'hCAFE0004);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
